// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the odd-parity
// helper that both the Tx and Rx sides use.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    function automatic logic odd_parity(input logic [UART_DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side bus of the UART receiver: received byte, its valid strobe, busy and
// per-frame error flags. master = receiver, slave = byte consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_out;
    logic                      data_valid;
    logic                      busy;
    logic                      frame_err;
    logic                      parity_err;

    modport master (
        output data_out,
        output data_valid,
        output busy,
        output frame_err,
        output parity_err
    );

    modport slave (
        input data_out,
        input data_valid,
        input busy,
        input frame_err,
        input parity_err
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial pin; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            meta <= rx_in;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, stop, odd parity. Parity checking is
// enabled by defining UART_RX_PARITY_CHECK_EN; otherwise parity_err stays 0.
//   state     | meaning
//   IDLE      | line idle, waiting for rx_s low
//   START     | counting to mid start bit to reject glitches
//   DATA      | sampling 8 data bits
//   STOP      | sampling stop bit
//   PARITY    | sampling parity bit, then publishing the frame
//   WAIT_IDLE | waiting for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_in,
    uart_rx_if.master rx_bus
);
    localparam int MID   = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] T_MID    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] T_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] T_DONE   = CNT_W'(CLKS_PER_BIT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    logic                      rx_s;
    rx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          timer_q, timer_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      stop_bad_q, stop_bad_d;
    logic                      par_q, par_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      ferr_q, ferr_d;
    logic                      perr_q, perr_d;
    logic                      par_bad;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_in (rx_in),
        .rx_s  (rx_s)
    );

`ifdef UART_RX_PARITY_CHECK_EN
    assign par_bad = (par_q != odd_parity(shift_q));
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        stop_bad_d = stop_bad_q;
        par_d      = par_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    // detect cycle counts as timer 0, so START begins at 1
                    state_d = ST_START;
                    timer_d = CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (timer_q == T_MID) begin
                    timer_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (timer_q == T_LAST) begin
                    timer_d        = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (timer_q == T_LAST) begin
                    timer_d    = '0;
                    stop_bad_d = ~rx_s;
                    state_d    = ST_PARITY;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                // timer overruns to CLKS_PER_BIT for the publish cycle after the sample
                if (timer_q == T_LAST) begin
                    par_d   = rx_s;
                    timer_d = T_DONE;
                end else if (timer_q == T_DONE) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    ferr_d  = stop_bad_q;
                    perr_d  = par_bad;
                    timer_d = '0;
                    state_d = ST_WAIT_IDLE;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            stop_bad_q <= 1'b0;
            par_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            stop_bad_q <= stop_bad_d;
            par_q      <= par_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
        end
    end

    assign rx_bus.data_out   = data_q;
    assign rx_bus.data_valid = valid_q;
    assign rx_bus.busy       = busy_q;
    assign rx_bus.frame_err  = ferr_q;
    assign rx_bus.parity_err = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two receivers (2 and 8 clocks per bit) fed by a behavioural
// transmitter; received frames are compared against a frame-level reference model.
module tb_uart_rx;
    localparam int CPB_A = 2;
    localparam int CPB_B = 8;
`ifdef UART_RX_PARITY_CHECK_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a  = 1'b1;
    logic rx_b  = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if bus_a ();
    uart_rx_if bus_b ();

    uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_in  (rx_a),
        .rx_bus (bus_a)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_in  (rx_b),
        .rx_bus (bus_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
    bit busy_seen_b = 1'b0;

    // record every valid strobe as {frame_err, parity_err, data}
    always @(negedge clk) begin
        if (bus_a.data_valid === 1'b1) got_a.push_back({bus_a.frame_err, bus_a.parity_err, bus_a.data_out});
        if (bus_b.data_valid === 1'b1) got_b.push_back({bus_b.frame_err, bus_b.parity_err, bus_b.data_out});
        if (bus_b.busy === 1'b1) busy_seen_b = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // frame-level model: a byte with correct parity has an odd total count of ones
    function automatic logic [9:0] model(input logic [7:0] b, input bit stop_v, input bit par_v);
        bit good_par;
        bit fe;
        bit pe;
        good_par = (($countones(b) + int'(par_v)) % 2) == 1;
        fe = !stop_v;
        pe = PEN && !good_par;
        return {fe, pe, b};
    endfunction

    function automatic bit correct_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic drive(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic send_frame(input int which, input logic [7:0] b, input bit stop_v,
                              input bit par_v, input int gap_bits, input int nbits);
        logic [10:0] bits;
        int cpb;
        bits = {par_v, stop_v, b, 1'b0};
        cpb  = (which == 0) ? CPB_A : CPB_B;
        for (int i = 0; i < nbits; i++) begin
            drive(which, bits[i]);
            repeat (cpb) @(negedge clk);
        end
        if (nbits == 11) @(negedge clk);
        drive(which, 1'b1);
        repeat (gap_bits * cpb) @(negedge clk);
    endtask

    task automatic send_exp(input int which, input logic [7:0] b, input bit stop_v,
                            input bit par_v, input int gap_bits);
        if (which == 0) exp_a.push_back(model(b, stop_v, par_v));
        else            exp_b.push_back(model(b, stop_v, par_v));
        send_frame(which, b, stop_v, par_v, gap_bits, 11);
    endtask

    function automatic int got_size(input int which);
        return (which == 0) ? got_a.size() : got_b.size();
    endfunction

    task automatic flush(input int which, input string tag);
        logic [9:0] g[$];
        logic [9:0] e[$];
        int k;
        int want;
        want = (which == 0) ? exp_a.size() : exp_b.size();
        k = 0;
        while (k < 4000 && got_size(which) < want) begin
            @(negedge clk);
            k++;
        end
        repeat (40) @(negedge clk);
        if (which == 0) begin
            g = got_a; e = exp_a; got_a.delete(); exp_a.delete();
        end else begin
            g = got_b; e = exp_b; got_b.delete(); exp_b.delete();
        end
        chk({tag, "_count"}, g.size(), e.size());
        while (g.size() > 0 && e.size() > 0) begin
            logic [9:0] gv, ev;
            gv = g.pop_front();
            ev = e.pop_front();
            chk({tag, "_data"}, gv[7:0], ev[7:0]);
            chk({tag, "_frame_err"}, gv[9], ev[9]);
            chk({tag, "_parity_err"}, gv[8], ev[8]);
        end
        chk({tag, "_busy_idle"}, (which == 0) ? bus_a.busy : bus_b.busy, 1'b0);
    endtask

    initial begin
        logic [7:0] rb;
        bit rs, rp;

        repeat (3) @(negedge clk);
        chk("rst_data", bus_a.data_out, 8'h00);
        chk("rst_valid", bus_a.data_valid, 1'b0);
        chk("rst_busy", bus_a.busy, 1'b0);
        chk("rst_ferr", bus_a.frame_err, 1'b0);
        chk("rst_perr", bus_a.parity_err, 1'b0);
        chk("rst_busy_b", bus_b.busy, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_exp(0, 8'hA5, 1'b1, correct_par(8'hA5), 2);
        flush(0, "a5");

        send_exp(0, 8'h3C, 1'b0, correct_par(8'h3C), 2);
        flush(0, "stop_bad");
        chk("held_data", bus_a.data_out, 8'h3C);
        chk("held_ferr", bus_a.frame_err, 1'b1);

        // abort 0xFF during data bit 3
        send_frame(0, 8'hFF, 1'b1, 1'b0, 0, 4);
        @(negedge clk);
        chk("mid_busy", bus_a.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", bus_a.data_out, 8'h00);
        chk("mid_rst_busy", bus_a.busy, 1'b0);
        chk("mid_rst_ferr", bus_a.frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("mid_rst_no_valid", got_a.size(), 0);
        send_exp(0, 8'h5A, 1'b1, correct_par(8'h5A), 2);
        flush(0, "after_rst");

        send_exp(0, 8'h00, 1'b1, 1'b0, 2);
        flush(0, "par_bad");

        send_exp(0, 8'h01, 1'b1, correct_par(8'h01), 1);
        send_exp(0, 8'h80, 1'b1, correct_par(8'h80), 2);
        flush(0, "b2b");

        busy_seen_b = 1'b0;
        rx_b = 1'b0;
        repeat (2) @(negedge clk);
        rx_b = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_busy_seen", busy_seen_b, 1'b1);
        chk("glitch_busy_low", bus_b.busy, 1'b0);
        chk("glitch_no_valid", got_b.size(), 0);

        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rp = correct_par(rb) ^ ($urandom_range(0, 2) == 0);
            send_exp(0, rb, rs, rp, $urandom_range(1, 3));
        end
        flush(0, "rand_a");

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rp = correct_par(rb) ^ ($urandom_range(0, 2) == 0);
            send_exp(1, rb, rs, rp, $urandom_range(1, 3));
        end
        flush(1, "rand_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
